// File: rtl/regs_arb_pkg.sv
// Shared types for the register-file access arbiter.
// Address width and the two-state access FSM encoding.
package regs_arb_pkg;

  localparam int ADDR_W = 4;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

endpackage

// File: rtl/regs_arb_rr_arb2.sv
// Two-way round-robin grant; one-hot output.
// last_grant=1 means requester 0 wins the next tie.
module rr_arb2 (
  input  logic       v0,
  input  logic       v1,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt
);

  logic p0;
  logic p1;

  assign p0 = v0 & (~v1 | last_grant);
  assign p1 = v1 & ~p0;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (1'b1)
        p0:      gnt = 2'b01;
        p1:      gnt = 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/regs_arb.sv
// Arbitrates core/debug access to the register file.
// Accept in IDLE, access for one cycle, respond the cycle after.
module regs_arb
  import regs_arb_pkg::*;
#(
  parameter int n = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [n-1:0]      req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [n-1:0]      req1_wdata,
  output logic              req1_ready,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [n-1:0]      resp_rdata,
  output logic              rf_w,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [n-1:0]      rf_wdata,
  input  logic [n-1:0]      rf_rdata
);

  state_t state, state_nx;

  logic              last_q;
  logic              we_q;
  logic              id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [n-1:0]      wdata_q;
  logic [1:0]        gnt;
  logic              acc;

  rr_arb2 u_arb (
    .v0         (req0_valid),
    .v1         (req1_valid),
    .last_grant (last_q),
    .en         (state == IDLE),
    .gnt        (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign acc        = |gnt;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (acc) state_nx = ACCESS;
      ACCESS:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Latch the winning request; the grant is one-hot so gnt[1] is the id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      id_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (acc) begin
      last_q  <= gnt[1];
      id_q    <= gnt[1];
      we_q    <= gnt[1] ? req1_we    : req0_we;
      addr_q  <= gnt[1] ? req1_addr  : req0_addr;
      wdata_q <= gnt[1] ? req1_wdata : req0_wdata;
    end
  end

  assign rf_addr  = addr_q;
  assign rf_wdata = wdata_q;
  assign rf_w     = (state == ACCESS) & we_q & (addr_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_rdata <= '0;
    end else if (state == ACCESS) begin
      resp_valid <= 1'b1;
      resp_id    <= id_q;
      resp_rdata <= we_q ? '0 : rf_rdata;
    end else begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/regs_arb.md
REGS_ARB -- requirements
Module: regs_arb

Interface
REQ-001 SHALL have parameter n, default 8, meaning data bus width (matches register file width).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1 each, meaning requester 0 (core) / 1 (debug) has a pending access.
REQ-005 SHALL have ports req0_we/req1_we, input, 1 each, meaning 1 = write, 0 = read.
REQ-006 SHALL have ports req0_addr/req1_addr, input, 4 each, meaning register index 0..15.
REQ-007 SHALL have ports req0_wdata/req1_wdata, input, n each, meaning write data.
REQ-008 SHALL have ports req0_ready/req1_ready, output, 1 each, meaning request accepted this cycle when the matching valid is also high.
REQ-009 SHALL have ports resp_valid (output, 1), resp_id (output, 1) and resp_rdata (output, n), meaning a one-cycle completion pulse, the requester it belongs to, and the read data.
REQ-010 SHALL have ports rf_w (output, 1), rf_addr (output, 4) and rf_wdata (output, n), meaning register-file write enable, address (wired to Raddr2) and write data.
REQ-011 SHALL have port rf_rdata, input, n, meaning the combinational register-file read data for rf_addr (%0 reads as 0).

Function
REQ-012 SHALL implement FSM states IDLE and ACCESS; IDLE -> ACCESS on any accept; ACCESS -> IDLE unconditionally after one cycle.
REQ-013 SHALL assert at most one reqX_ready per cycle, only in IDLE, and only toward the granted requester whose valid is high.
REQ-014 SHALL grant the sole valid requester when only one is valid.
REQ-015 SHALL grant round-robin when both are valid: the requester not granted last; last_grant updates only on accept.
REQ-016 SHALL latch we, addr, wdata and requester id on accept at edge T.
REQ-017 SHALL, during ACCESS (cycle T+1), drive rf_addr and rf_wdata from the latched values and rf_w = latched_we AND (latched_addr != 0).
REQ-018 SHALL suppress the register-file write for address 0, while still completing the transaction normally.
REQ-019 SHALL drive rf_w = 0 in IDLE, with rf_addr/rf_wdata holding their last latched values.
REQ-020 SHALL, at the edge ending ACCESS, register resp_rdata = rf_rdata for reads and 0 for writes, set resp_id = latched id, and assert resp_valid for exactly cycle T+2.
REQ-021 SHALL guarantee read latency = 2 cycles from accept to resp_valid, and throughput = 1 transaction per 2 cycles (a new accept is allowed in the resp_valid cycle).
REQ-022 SHALL provide no response backpressure; the requester must sample resp_valid when it is high.
REQ-023 SHALL ignore requests that deassert valid before being accepted, leaving no state change.
REQ-024 SHALL return the newly written value to a read of the same address accepted immediately after a write, because the write commits at the end of ACCESS.

Reset
REQ-025 SHALL, on rst_n low (asynchronous), force state=IDLE, last_grant=1 (so requester 0 wins the first tie), resp_valid=0, resp_id=0, resp_rdata=0, rf_w=0, rf_addr=0, rf_wdata=0 and latched registers=0.
REQ-026 SHALL abort any transaction in flight when reset is asserted mid-ACCESS: no write is committed after reset assertion and no resp_valid is issued.
REQ-027 SHALL allow the first accept at the first rising edge after rst_n deasserts.

Structure
REQ-028 SHALL place the state enum (IDLE, ACCESS) and constant ADDR_W=4 in package regs_arb_pkg.
REQ-029 SHALL implement grant logic in sub-module rr_arb2 (inputs: two valids, last_grant, enable; outputs: one-hot grant).
REQ-030 SHALL keep all outputs except reqX_ready and rf_w registered, and derive those two combinationally from registered state only (plus the valids for ready).

Verification
REQ-031 SHALL cover: req0 write addr 5 data 0xA7, then req0 read addr 5 -> rf_w pulse with rf_addr=5, rf_wdata=0xA7; read resp_valid at accept+2 with resp_rdata=0xA7, resp_id=0.
REQ-032 SHALL cover: both valid continuously after reset, reads of addr 1 and 2 -> grants alternate 0,1,0,1 and each accept is 2 cycles apart.
REQ-033 SHALL cover: req1 write addr 0 data 0xFF -> rf_w stays 0, resp_valid pulses with resp_rdata=0, resp_id=1; subsequent read of addr 0 returns 0.
REQ-034 SHALL cover: rst_n low during ACCESS of a write to addr 3 data 0x55 -> rf_w=0 immediately, no resp_valid, and a read of addr 3 after reset does not return 0x55 (prior value 0x00).
REQ-035 SHALL cover: req0_valid pulsed high for one cycle while in ACCESS, then dropped -> no accept, no response.
